// File: rtl/ifetch_queue_if.sv
// Instruction fetch queue bus bundle: redirect input, memory request/response
// channel and the decode-side valid/ready channel.
// master = the fetch queue itself, slave = the surrounding core/memory/decode.
interface ifetch_queue_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    modport master (
        input  redirect_valid, redirect_pc,
        output mem_req, mem_addr,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output inst_valid, inst_data, inst_pc,
        input  inst_ready
    );

    modport slave (
        output redirect_valid, redirect_pc,
        input  mem_req, mem_addr,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  inst_valid, inst_data, inst_pc,
        output inst_ready
    );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues word reads from a running fetch PC, buffers
// returned words with their PCs in a DEPTH-entry FIFO and hands them to decode.
// A redirect flushes the FIFO and discards every fetch still in flight.
// Requests are only issued when a FIFO slot is guaranteed for the response,
// so the FIFO can never overflow.
// Optional macro IFQ_BYPASS_EN: a response arriving while the FIFO is empty
// is presented to decode in the same cycle (zero-cycle fetch latency).
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic          clk,
    input  logic          rst,
    ifetch_queue_if.master bus
);
    localparam int           AW      = $clog2(DEPTH);
    localparam int           CW      = AW + 1;
    localparam logic [CW:0]  DEPTH_L = (CW+1)'(DEPTH);

    typedef enum logic [1:0] {FETCH, STALL, FLUSH} state_t;

    state_t          state_reg, state_next;
    logic [31:0]     fetch_pc_reg, fetch_pc_next;
    logic [31:0]     resp_pc_reg, resp_pc_next;
    logic [CW-1:0]   count_reg, count_next;
    logic [CW-1:0]   outstanding_reg, outstanding_next;
    logic [CW-1:0]   discard_reg, discard_next;
    logic [AW-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [31:0]     data_mem_reg [DEPTH];
    logic [31:0]     pc_mem_reg   [DEPTH];

    logic            xfer;
    logic            resp_take;
    logic            resp_keep;
    logic            bypass_hit;
    logic            head_valid;
    logic            pop;
    logic            pop_fifo;
    logic            push;
    logic [CW:0]     used_now;
    logic [CW:0]     used_next;
    logic            credit_now;
    logic            credit_next;

    // Handshake decode, counter arithmetic and output muxing
    always_comb begin
        used_now   = {1'b0, count_reg} + {1'b0, outstanding_reg};
        credit_now = (used_now < DEPTH_L);
        // Gated by reset so the request line is quiet while reset is held
        bus.mem_req  = rst && (state_reg == FETCH) && credit_now;
        bus.mem_addr = fetch_pc_reg;

        xfer      = bus.mem_req && bus.mem_gnt;
        // A response with nothing outstanding is a protocol error and is ignored
        resp_take = bus.mem_rvalid && (outstanding_reg != '0);
        // Responses are dropped while discarding and in a redirect cycle
        resp_keep = resp_take && (discard_reg == '0) && !bus.redirect_valid;

        head_valid = (count_reg != '0);
`ifdef IFQ_BYPASS_EN
        bypass_hit = resp_keep && !head_valid;
`else
        bypass_hit = 1'b0;
`endif
        bus.inst_valid = head_valid || bypass_hit;
        if (bypass_hit) begin
            bus.inst_data = bus.mem_rdata;
            bus.inst_pc   = resp_pc_reg;
        end else if (head_valid) begin
            bus.inst_data = data_mem_reg[rd_ptr_reg];
            bus.inst_pc   = pc_mem_reg[rd_ptr_reg];
        end else begin
            bus.inst_data = '0;
            bus.inst_pc   = '0;
        end

        // Redirect wins over the decode handshake
        pop      = bus.inst_valid && bus.inst_ready && !bus.redirect_valid;
        pop_fifo = pop && head_valid;
        // A bypassed word consumed by decode never touches the FIFO
        push     = resp_keep && !(bypass_hit && bus.inst_ready);

        outstanding_next = outstanding_reg + CW'(xfer) - CW'(resp_take);

        if (bus.redirect_valid) begin
            count_next    = '0;
            wr_ptr_next   = '0;
            rd_ptr_next   = '0;
            fetch_pc_next = bus.redirect_pc;
            resp_pc_next  = bus.redirect_pc;
            // Everything still in flight (including this cycle's grant) is stale
            discard_next  = outstanding_next;
        end else begin
            count_next    = count_reg + CW'(push) - CW'(pop_fifo);
            wr_ptr_next   = wr_ptr_reg + AW'(push);
            rd_ptr_next   = rd_ptr_reg + AW'(pop_fifo);
            fetch_pc_next = xfer ? fetch_pc_reg + PC_STEP : fetch_pc_reg;
            resp_pc_next  = resp_keep ? resp_pc_reg + PC_STEP : resp_pc_reg;
            discard_next  = discard_reg - CW'(resp_take && (discard_reg != '0));
        end

        used_next   = {1'b0, count_next} + {1'b0, outstanding_next};
        credit_next = (used_next < DEPTH_L);
    end

    // Next-state logic: stall on credit exhaustion, flush while stale fetches remain
    always_comb begin
        state_next = state_reg;
        if (bus.redirect_valid) begin
            state_next = (outstanding_next != '0) ? FLUSH : FETCH;
        end else begin
            case (state_reg)
                FLUSH: begin
                    if (discard_next == '0)
                        state_next = credit_next ? FETCH : STALL;
                end
                FETCH, STALL: begin
                    state_next = credit_next ? FETCH : STALL;
                end
                default: state_next = FETCH;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= FETCH;
        else      state_reg <= state_next;
    end

    // PCs, counters and FIFO pointers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_reg    <= RESET_PC;
            resp_pc_reg     <= RESET_PC;
            count_reg       <= '0;
            outstanding_reg <= '0;
            discard_reg     <= '0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
        end else begin
            fetch_pc_reg    <= fetch_pc_next;
            resp_pc_reg     <= resp_pc_next;
            count_reg       <= count_next;
            outstanding_reg <= outstanding_next;
            discard_reg     <= discard_next;
            wr_ptr_reg      <= wr_ptr_next;
            rd_ptr_reg      <= rd_ptr_next;
        end
    end

    // FIFO storage: word and its PC written together at the tail
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_mem_reg[i] <= '0;
                pc_mem_reg[i]   <= '0;
            end
        end else if (push) begin
            data_mem_reg[wr_ptr_reg] <= bus.mem_rdata;
            pc_mem_reg[wr_ptr_reg]   <= resp_pc_reg;
        end
    end
endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue. A queue-based reference model tracks
// in-flight fetches (marked stale by redirects) and buffered instructions;
// outputs are sampled 1 time unit after the falling edge.
module tb_ifetch_queue;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ifetch_queue_if bus();

    ifetch_queue #(
        .DEPTH   (DEPTH),
        .RESET_PC(32'h0000_0000),
        .PC_STEP (32'd4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct { logic [31:0] addr; bit stale; } flight_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } inst_t;
    flight_t     inflight[$];
    inst_t       fifo_q[$];
    logic [31:0] m_fetch = 32'h0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
    endfunction

    function automatic int stale_cnt();
        int n = 0;
        foreach (inflight[i]) if (inflight[i].stale) n++;
        return n;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // modes: 0 stray rvalid, 1 full speed, 2 decode stalled, 3 no grant,
    //        4 random, 6 redirect to rpc, 7 grant without responses
    task automatic step(input int mode, input logic [31:0] rpc_in);
        bit red, gnt, rv, rdy, exp_req, exp_valid, byp, have_resp, resp_good, xfer;
        logic [31:0] rpc, rnd;
        inst_t head;
        flight_t e;
        red = 0; rpc = rpc_in;
        gnt = 0; rv = 0; rdy = 0;
        @(negedge clk);
        case (mode)
            0: begin gnt = 0; rv = 1; rdy = 1; end
            1: begin gnt = 1; rv = inflight.size() > 0; rdy = 1; end
            2: begin gnt = 1; rv = inflight.size() > 0; rdy = 0; end
            3: begin gnt = 0; rv = inflight.size() > 0; rdy = 1; end
            4: begin
                gnt = ($urandom % 4) != 0;
                rv  = (inflight.size() > 0) && (($urandom % 3) != 0);
                rdy = ($urandom % 4) != 0;
                red = ($urandom % 16) == 0;
                case ($urandom % 4)
                    0: rpc = 32'h0000_0100;
                    1: rpc = 32'hFFFF_FFF8;
                    2: rpc = 32'hFFFF_FFF0;
                    default: begin rnd = $urandom; rpc = {rnd[31:2], 2'b00}; end
                endcase
            end
            6: begin gnt = 1; rv = inflight.size() > 0; rdy = 1; red = 1; end
            default: begin gnt = 1; rv = 0; rdy = 1; end
        endcase
        bus.redirect_valid = red;
        bus.redirect_pc    = rpc;
        bus.mem_gnt        = gnt;
        bus.mem_rvalid     = rv;
        bus.mem_rdata      = (rv && inflight.size() > 0) ? memf(inflight[0].addr) : $urandom;
        bus.inst_ready     = rdy;
        #1;
        exp_req   = (stale_cnt() == 0) && (fifo_q.size() + inflight.size() < DEPTH);
        have_resp = rv && (inflight.size() > 0);
        resp_good = have_resp && !inflight[0].stale && !red;
        byp = 0;
`ifdef IFQ_BYPASS_EN
        byp = resp_good && (fifo_q.size() == 0);
`endif
        exp_valid = (fifo_q.size() > 0) || byp;
        check_val("mem_req", {31'b0, bus.mem_req}, {31'b0, exp_req});
        if (exp_req) check_val("mem_addr", bus.mem_addr, m_fetch);
        check_val("inst_valid", {31'b0, bus.inst_valid}, {31'b0, exp_valid});
        if (exp_valid) begin
            if (byp) begin head.pc = inflight[0].addr; head.data = memf(inflight[0].addr); end
            else head = fifo_q[0];
            check_val("inst_pc", bus.inst_pc, head.pc);
            check_val("inst_data", bus.inst_data, head.data);
        end
        @(posedge clk);
        xfer = exp_req && gnt;
        if (have_resp) begin
            e = inflight.pop_front();
            if (resp_good) begin head.pc = e.addr; head.data = memf(e.addr); end
        end
        if (!red) begin
            if (byp) begin
                if (rdy) $display("deliver pc=%h data=%h (bypass)", head.pc, head.data);
                else fifo_q.push_back(head);
            end else begin
                if (rdy && fifo_q.size() > 0) begin
                    $display("deliver pc=%h data=%h", fifo_q[0].pc, fifo_q[0].data);
                    void'(fifo_q.pop_front());
                end
                if (resp_good) fifo_q.push_back(head);
            end
        end
        if (xfer) begin
            inflight.push_back('{addr: m_fetch, stale: red});
            m_fetch = m_fetch + 32'd4;
        end
        if (red) begin
            foreach (inflight[i]) inflight[i].stale = 1;
            fifo_q.delete();
            m_fetch = rpc;
            $display("redirect to %h, %0d fetches discarded", rpc, inflight.size());
        end
    endtask

    task automatic run(input int mode, input int n);
        for (int i = 0; i < n; i++) step(mode, 32'h0);
    endtask

    initial begin
        bus.redirect_valid = 0;
        bus.redirect_pc    = 0;
        bus.mem_gnt        = 0;
        bus.mem_rvalid     = 0;
        bus.mem_rdata      = 0;
        bus.inst_ready     = 0;
        rst = 0;
        repeat (2) @(negedge clk);
        #1;
        check_val("rst_mem_req", {31'b0, bus.mem_req}, 32'h0);
        check_val("rst_inst_valid", {31'b0, bus.inst_valid}, 32'h0);
        check_val("rst_mem_addr", bus.mem_addr, 32'h0);
        check_val("rst_inst_data", bus.inst_data, 32'h0);
        check_val("rst_inst_pc", bus.inst_pc, 32'h0);
        @(negedge clk);
        rst = 1;

        run(0, 3);                      // stray responses with nothing outstanding
        run(1, 12);                     // streaming fetch
        run(2, 8);                      // decode stalled -> credit limit
        run(1, 1);                      // single-cycle ready pulse
        run(2, 4);
        run(3, 6);                      // grant withheld, request must hold
        run(1, 4);
        run(7, 3);                      // build up outstanding requests
        step(6, 32'h0000_0100);         // redirect with grant and response
        run(1, 10);
        step(6, 32'hFFFF_FFF8);         // wrap-around target
        run(1, 10);
        run(4, 1500);                   // random traffic with redirects
        run(1, 20);                     // drain

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
Consumer side of the program counter: the block takes a fetch PC and turns it into an in-order instruction stream.
- Issues word reads to instruction memory over a req/gnt request channel and an in-order rvalid response channel.
- Buffers returned words with their PCs in a DEPTH-entry FIFO.
- Hands them to decode over a valid/ready handshake.
- Accepts a redirect (branch/jump target) that flushes buffered and in-flight fetches.

Parameters:
DEPTH, 4, FIFO entries and maximum in-flight requests; power of two, at least 2
RESET_PC, 32'h0000_0000, first fetch address after reset
PC_STEP, 32'd4, PC increment per fetched word

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
redirect_valid  in  1  redirect request, single-cycle pulse
redirect_pc  in  32  new fetch address, word aligned
mem_req  out  1  read request valid
mem_addr  out  32  read address
mem_gnt  in  1  request accepted this cycle
mem_rvalid  in  1  response valid; responses return in request order
mem_rdata  in  32  response data
inst_valid  out  1  instruction available to decode
inst_ready  in  1  decode accepts
inst_data  out  32  instruction word
inst_pc  out  32  address of inst_data

Behaviour:
- Reset (rst=0, asynchronous):
  - fetch_pc=RESET_PC, resp_pc=RESET_PC.
  - FIFO empty, outstanding=0, discard=0, state=FETCH.
  - Outputs: mem_req=0, inst_valid=0, mem_addr=RESET_PC, inst_data=0, inst_pc=0.
- Request channel:
  - mem_addr=fetch_pc.
  - A transfer occurs when mem_req&&mem_gnt; on a transfer fetch_pc+=PC_STEP (mod 2^32, wrap from 32'hFFFF_FFFC to 0) and outstanding+=1.
  - Once asserted, mem_req is held with a stable mem_addr until granted, unless a redirect arrives.
- Credit rule: mem_req=1 only in state FETCH and only when fifo_count+outstanding<DEPTH. A response therefore always finds a free FIFO slot; no overflow path exists.
- Response channel:
  - Each mem_rvalid decrements outstanding.
  - If discard>0: the word is dropped and discard-=1.
  - Otherwise {mem_rdata, resp_pc} is written to the FIFO and resp_pc+=PC_STEP.
- Output channel:
  - inst_valid=(fifo_count>0); inst_data/inst_pc come from the FIFO head.
  - Pop on inst_valid&&inst_ready.
  - Push and pop in the same cycle leave the count unchanged.
  - Write-to-visible latency is 1 cycle.
- State machine:
  - FETCH -> STALL when the credit rule blocks a new request.
  - STALL -> FETCH when a credit frees (pop or response).
  - Any state -> FLUSH on redirect_valid when outstanding (after this cycle's response) is >0.
  - Any state -> FETCH on redirect_valid when nothing is in flight.
  - FLUSH -> FETCH when discard reaches 0.
  - FLUSH never issues requests.
- Redirect cycle (highest priority):
  - FIFO cleared; inst_valid=0 next cycle; the current-cycle pop is ignored for ordering purposes.
  - fetch_pc=resp_pc=redirect_pc.
  - discard=outstanding after accounting for this cycle's grant and response; a request granted in the redirect cycle is counted as discarded.
  - The response arriving in the redirect cycle is dropped.
  - mem_req deasserts the cycle after a redirect when discard>0.
- Back-to-back redirects: the later one wins; discard accumulates correctly because it is always recomputed from outstanding.
- outstanding and discard counters are log2(DEPTH)+1 bits wide.
- A response with outstanding=0 is a protocol error; the block ignores it (no FIFO write, no underflow).

Optional Feature:
IFQ_BYPASS_EN
- Defined: when the FIFO is empty, discard=0 and mem_rvalid=1, the response is presented combinationally on inst_data/inst_pc with inst_valid=1 in the same cycle.
  - If inst_ready=1, it is consumed without a FIFO write.
  - Otherwise it is written normally.
  - Zero-cycle fetch latency.
- Undefined: inst_valid is purely registered from FIFO state; response-to-decode latency is 1 cycle.

Test Plan:
- Reset release, mem_gnt=1, mem_rvalid one cycle after each grant, inst_ready=1 -> mem_addr sequence 0,4,8,C..., inst_pc 0,4,8 with matching data; inst_valid first high 2 cycles after first grant (1 with IFQ_BYPASS_EN).
- inst_ready=0, DEPTH=4, memory always grants -> exactly 4 grants then mem_req=0 (STALL). Raise inst_ready for 1 cycle -> exactly one more request, addr 32'h10.
- mem_gnt=0 for 5 cycles -> mem_req held 1, mem_addr stable at current fetch_pc, no counter changes.
- 3 requests outstanding, redirect_pc=32'h100 -> FLUSH. The 3 old responses are dropped. The next request has addr 32'h100 and the first delivered inst_pc is 32'h100.
- Redirect in the same cycle as a grant and a response -> both the granted request's data and the current response are discarded. No stale word ever appears on inst_data.
- fetch_pc starts at 32'hFFFF_FFF8 via redirect -> delivered inst_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
